// File: rtl/calendar_pkg.sv
// Calendar field widths, month constants and date helpers shared by the timer,
// display and alarm-setting logic.
package calendar_pkg;

    localparam int FIELD_W = 8;

    localparam logic [FIELD_W-1:0] SEC_MAX   = 8'd59;
    localparam logic [FIELD_W-1:0] MIN_MAX   = 8'd59;
    localparam logic [FIELD_W-1:0] HOUR_MAX  = 8'd23;
    localparam logic [FIELD_W-1:0] DAY_MIN   = 8'd1;
    localparam logic [FIELD_W-1:0] MONTH_MIN = 8'd1;
    localparam logic [FIELD_W-1:0] MONTH_MAX = 8'd12;

    typedef enum logic [FIELD_W-1:0] {
        JAN = 8'd1, FEB = 8'd2, MAR = 8'd3, APR = 8'd4,
        MAY = 8'd5, JUN = 8'd6, JUL = 8'd7, AUG = 8'd8,
        SEP = 8'd9, OCT = 8'd10, NOV = 8'd11, DEC = 8'd12
    } month_e;

    // Gregorian rule: every 4th year, except centuries not divisible by 400.
    function automatic logic is_leap(input int unsigned year);
        return ((year % 4) == 0) && (((year % 100) != 0) || ((year % 400) == 0));
    endfunction

    // Out-of-range months report 31; callers range-check the month separately.
    function automatic logic [FIELD_W-1:0] days_in_month(input logic [FIELD_W-1:0] month,
                                                         input int unsigned year);
        logic [FIELD_W-1:0] dim;
        case (month)
            FEB:                dim = is_leap(year) ? 8'd29 : 8'd28;
            APR, JUN, SEP, NOV: dim = 8'd30;
            default:            dim = 8'd31;
        endcase
        return dim;
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// Loadable MIN..max counter that wraps to MIN; carry flags the wrapping increment
// combinationally so a whole chain of fields settles in the same cycle.
module wrap_counter #(
    parameter int             W       = 8,
    parameter int             MIN     = 0,
    parameter logic [W-1:0]   RST_VAL = W'(MIN)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         load,
    input  logic [W-1:0] ld_val,
    input  logic [W-1:0] max,
    output logic [W-1:0] value,
    output logic         carry
);

    assign carry = inc && (value == max);

    // NOTE: non-blocking assignment so every field in the chain samples the
    // pre-edge values of its neighbours, whatever the evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value <= RST_VAL;
        end else if (load) begin
            value <= ld_val;
        end else if (inc) begin
            value <= carry ? W'(MIN) : value + 1'b1;
        end
    end

endmodule

// File: rtl/calendar_timer.sv
// Single-clock calendar: prescaler -> second/minute/hour/day/month/year chain
// with run control, validated loading and a minute-resolution alarm.
module calendar_timer
    import calendar_pkg::*;
#(
    parameter int CLK_DIV   = 50_000_000,
    parameter int YEAR_W    = 12,
    parameter int BASE_YEAR = 2000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              load,
    input  logic [7:0]        ld_second,
    input  logic [7:0]        ld_minute,
    input  logic [7:0]        ld_hour,
    input  logic [7:0]        ld_day,
    input  logic [7:0]        ld_month,
    input  logic [YEAR_W-1:0] ld_year,
    input  logic              alarm_en,
    input  logic [7:0]        alarm_hour,
    input  logic [7:0]        alarm_minute,
    output logic [7:0]        second,
    output logic [7:0]        minute,
    output logic [7:0]        hour,
    output logic [7:0]        day,
    output logic [7:0]        month,
    output logic [YEAR_W-1:0] year,
    output logic              running,
    output logic              sec_tick,
    output logic              alarm,
    output logic              load_err
);

    localparam int                PS_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PS_W-1:0]   PS_LAST  = PS_W'(CLK_DIV - 1);
    localparam logic [YEAR_W-1:0] YEAR_MAX = '1;

    logic [PS_W-1:0] prescaler;
    logic            tick;
    logic            cnt_tick;
    logic            ld_valid;
    logic            load_ok;
    logic [7:0]      ld_dim;
    logic [7:0]      dim;
    logic            sec_carry, min_carry, hour_carry, day_carry, month_carry;
    logic            year_carry_unused;
    logic [7:0]      next_minute;
    logic [7:0]      next_hour;
    logic            alarm_hit;

    // ---------------- run flag and prescaler ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            running <= 1'b0;
        end else if (stop) begin
            running <= 1'b0;
        end else if (start) begin
            running <= 1'b1;
        end
    end

    assign tick = running && (prescaler == PS_LAST);

    // A load request owns the cycle: any coincident tick is dropped entirely.
    assign cnt_tick = tick && !load;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescaler <= '0;
        end else if (load_ok) begin
            prescaler <= '0;
        end else if (running) begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
        end
    end

    // ---------------- load validation ----------------
    assign ld_dim   = days_in_month(ld_month, 32'(ld_year));
    assign ld_valid = (ld_second <= SEC_MAX) && (ld_minute <= MIN_MAX) &&
                      (ld_hour <= HOUR_MAX) &&
                      (ld_month >= MONTH_MIN) && (ld_month <= MONTH_MAX) &&
                      (ld_day >= DAY_MIN) && (ld_day <= ld_dim);
    assign load_ok  = load && ld_valid;

    // ---------------- field chain ----------------
    assign dim = days_in_month(month, 32'(year));

    wrap_counter #(.W(8), .MIN(0)) u_second (
        .clk(clk), .reset(reset), .inc(cnt_tick), .load(load_ok),
        .ld_val(ld_second), .max(SEC_MAX), .value(second), .carry(sec_carry)
    );

    wrap_counter #(.W(8), .MIN(0)) u_minute (
        .clk(clk), .reset(reset), .inc(sec_carry), .load(load_ok),
        .ld_val(ld_minute), .max(MIN_MAX), .value(minute), .carry(min_carry)
    );

    wrap_counter #(.W(8), .MIN(0)) u_hour (
        .clk(clk), .reset(reset), .inc(min_carry), .load(load_ok),
        .ld_val(ld_hour), .max(HOUR_MAX), .value(hour), .carry(hour_carry)
    );

    wrap_counter #(.W(8), .MIN(1)) u_day (
        .clk(clk), .reset(reset), .inc(hour_carry), .load(load_ok),
        .ld_val(ld_day), .max(dim), .value(day), .carry(day_carry)
    );

    wrap_counter #(.W(8), .MIN(1)) u_month (
        .clk(clk), .reset(reset), .inc(day_carry), .load(load_ok),
        .ld_val(ld_month), .max(MONTH_MAX), .value(month), .carry(month_carry)
    );

    wrap_counter #(.W(YEAR_W), .MIN(0), .RST_VAL(YEAR_W'(BASE_YEAR))) u_year (
        .clk(clk), .reset(reset), .inc(month_carry), .load(load_ok),
        .ld_val(ld_year), .max(YEAR_MAX), .value(year), .carry(year_carry_unused)
    );

    // ---------------- alarm compare on the post-tick time ----------------
    // sec_carry already implies a counted tick that lands on second 0.
    assign next_minute = min_carry  ? 8'd0 : minute + 8'd1;
    assign next_hour   = hour_carry ? 8'd0 : (min_carry ? hour + 8'd1 : hour);
    assign alarm_hit   = alarm_en && sec_carry &&
                         (next_minute == alarm_minute) && (next_hour == alarm_hour);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sec_tick <= 1'b0;
            alarm    <= 1'b0;
            load_err <= 1'b0;
        end else begin
            sec_tick <= cnt_tick;
            alarm    <= alarm_hit;
            load_err <= load && !ld_valid;
        end
    end

endmodule

// File: tb/tb_calendar_timer.sv
// Scoreboard bench for calendar_timer: expected outputs are queued as stimulus
// is driven and compared after the clock edge that should produce them.
module tb_calendar_timer;

    localparam int CLK_DIV   = 4;
    localparam int YEAR_W    = 12;
    localparam int BASE_YEAR = 2000;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start, stop, load, alarm_en;
    logic [7:0]        ld_second, ld_minute, ld_hour, ld_day, ld_month;
    logic [YEAR_W-1:0] ld_year;
    logic [7:0]        alarm_hour, alarm_minute;
    logic [7:0]        second, minute, hour, day, month;
    logic [YEAR_W-1:0] year;
    logic              running, sec_tick, alarm, load_err;

    logic              start1;
    logic [7:0]        second1, minute1, hour1, day1, month1;
    logic [YEAR_W-1:0] year1;
    logic              running1, sec_tick1, alarm1, load_err1;

    always #5 clk = ~clk;

    calendar_timer #(.CLK_DIV(CLK_DIV), .YEAR_W(YEAR_W), .BASE_YEAR(BASE_YEAR)) dut (
        .clk(clk), .reset(rst_n), .start(start), .stop(stop), .load(load),
        .ld_second(ld_second), .ld_minute(ld_minute), .ld_hour(ld_hour),
        .ld_day(ld_day), .ld_month(ld_month), .ld_year(ld_year),
        .alarm_en(alarm_en), .alarm_hour(alarm_hour), .alarm_minute(alarm_minute),
        .second(second), .minute(minute), .hour(hour), .day(day), .month(month),
        .year(year), .running(running), .sec_tick(sec_tick), .alarm(alarm),
        .load_err(load_err)
    );

    // Divide-by-one instance: a tick on every running cycle.
    calendar_timer #(.CLK_DIV(1), .YEAR_W(YEAR_W), .BASE_YEAR(BASE_YEAR)) dut1 (
        .clk(clk), .reset(rst_n), .start(start1), .stop(1'b0), .load(1'b0),
        .ld_second(8'd0), .ld_minute(8'd0), .ld_hour(8'd0),
        .ld_day(8'd0), .ld_month(8'd0), .ld_year(12'd0),
        .alarm_en(1'b0), .alarm_hour(8'd0), .alarm_minute(8'd0),
        .second(second1), .minute(minute1), .hour(hour1), .day(day1), .month(month1),
        .year(year1), .running(running1), .sec_tick(sec_tick1), .alarm(alarm1),
        .load_err(load_err1)
    );

    typedef struct {
        string tag;
        int    s, mi, h, d, mo, y;
        int    run, tk, al, er;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic expect_out(input string tag, input int s, input int mi, input int h,
                              input int d, input int mo, input int y,
                              input int run, input int tk, input int al, input int er);
        exp_t e;
        e.tag = tag; e.s = s; e.mi = mi; e.h = h; e.d = d; e.mo = mo; e.y = y;
        e.run = run; e.tk = tk; e.al = al; e.er = er;
        sb.push_back(e);
    endtask

    task automatic score();
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        check({e.tag, ".second"},   32'(second),   e.s);
        check({e.tag, ".minute"},   32'(minute),   e.mi);
        check({e.tag, ".hour"},     32'(hour),     e.h);
        check({e.tag, ".day"},      32'(day),      e.d);
        check({e.tag, ".month"},    32'(month),    e.mo);
        check({e.tag, ".year"},     32'(year),     e.y);
        check({e.tag, ".running"},  32'(running),  e.run);
        check({e.tag, ".sec_tick"}, 32'(sec_tick), e.tk);
        check({e.tag, ".alarm"},    32'(alarm),    e.al);
        check({e.tag, ".load_err"}, 32'(load_err), e.er);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int s, input int mi, input int h,
                           input int d, input int mo, input int y);
        ld_second = 8'(s); ld_minute = 8'(mi); ld_hour = 8'(h);
        ld_day = 8'(d); ld_month = 8'(mo); ld_year = YEAR_W'(y);
        load = 1'b1;
        cyc();
        load = 1'b0;
    endtask

    // Invalid load vectors {s, mi, h, d, mo, y}
    int bad[7][6] = '{
        '{0,  0,  0, 31,  4, 2024},
        '{0,  0,  0, 29,  2, 2023},
        '{60, 0,  0,  1,  1, 2024},
        '{0,  60, 0,  1,  1, 2024},
        '{0,  0,  24, 1,  1, 2024},
        '{0,  0,  0,  1, 13, 2024},
        '{0,  0,  0,  0,  5, 2024}
    };

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        start = 0; stop = 0; load = 0; alarm_en = 0; start1 = 0;
        ld_second = 0; ld_minute = 0; ld_hour = 0; ld_day = 0; ld_month = 0; ld_year = 0;
        alarm_hour = 0; alarm_minute = 0;
        rst_n = 0;
        repeat (2) cyc();
        expect_out("reset", 0, 0, 0, 1, 1, 2000, 0, 0, 0, 0);
        score();
        rst_n = 1;
        cyc();

        // Start: running rises next cycle, ticks every CLK_DIV cycles
        start = 1; start1 = 1;
        expect_out("start", 0, 0, 0, 1, 1, 2000, 1, 0, 0, 0);
        cyc(); score();
        check("div1.running", 32'(running1), 32'd1);
        start = 0; start1 = 0;
        cyc();
        check("div1.tick1", 32'(sec_tick1), 32'd1);
        check("div1.second1", 32'(second1), 32'd1);
        cyc();
        check("div1.second2", 32'(second1), 32'd2);
        expect_out("pre_tick1", 0, 0, 0, 1, 1, 2000, 1, 0, 0, 0);
        cyc(); score();
        expect_out("tick1", 1, 0, 0, 1, 1, 2000, 1, 1, 0, 0);
        cyc(); score();
        repeat (CLK_DIV - 1) cyc();
        expect_out("tick2", 2, 0, 0, 1, 1, 2000, 1, 1, 0, 0);
        cyc(); score();
        expect_out("tick2_end", 2, 0, 0, 1, 1, 2000, 1, 0, 0, 0);
        cyc(); score();
        cyc();

        // Stop mid-second, then resume: prescaler must keep its count
        stop = 1;
        expect_out("stop", 2, 0, 0, 1, 1, 2000, 0, 0, 0, 0);
        cyc(); score();
        stop = 0;
        repeat (8) cyc();
        expect_out("frozen", 2, 0, 0, 1, 1, 2000, 0, 0, 0, 0);
        score();
        start = 1;
        expect_out("restart", 2, 0, 0, 1, 1, 2000, 1, 0, 0, 0);
        cyc(); score();
        start = 0;
        expect_out("resume_tick", 3, 0, 0, 1, 1, 2000, 1, 1, 0, 0);
        cyc(); score();

        // New year full-chain carry
        expect_out("ny_load", 59, 59, 23, 31, 12, 2023, 1, 0, 0, 0);
        do_load(59, 59, 23, 31, 12, 2023); score();
        repeat (CLK_DIV - 2) cyc();
        expect_out("ny_pre", 59, 59, 23, 31, 12, 2023, 1, 0, 0, 0);
        cyc(); score();
        expect_out("ny_tick", 0, 0, 0, 1, 1, 2024, 1, 1, 0, 0);
        cyc(); score();

        // February ends: 2100 not leap, 2000 leap
        expect_out("feb2100_load", 59, 59, 23, 28, 2, 2100, 1, 0, 0, 0);
        do_load(59, 59, 23, 28, 2, 2100); score();
        repeat (CLK_DIV - 1) cyc();
        expect_out("feb2100_tick", 0, 0, 0, 1, 3, 2100, 1, 1, 0, 0);
        cyc(); score();
        expect_out("feb2000_load", 59, 59, 23, 28, 2, 2000, 1, 0, 0, 0);
        do_load(59, 59, 23, 28, 2, 2000); score();
        repeat (CLK_DIV - 1) cyc();
        expect_out("feb2000_tick", 0, 0, 0, 29, 2, 2000, 1, 1, 0, 0);
        cyc(); score();

        // Rejected loads with the timer stopped
        stop = 1;
        cyc();
        stop = 0;
        for (int i = 0; i < 7; i++) begin
            expect_out($sformatf("bad_load%0d", i), 0, 0, 0, 29, 2, 2000, 0, 0, 0, 1);
            do_load(bad[i][0], bad[i][1], bad[i][2], bad[i][3], bad[i][4], bad[i][5]);
            score();
            expect_out($sformatf("bad_load%0d_end", i), 0, 0, 0, 29, 2, 2000, 0, 0, 0, 0);
            cyc(); score();
        end
        expect_out("leap_load", 30, 20, 10, 29, 2, 2024, 0, 0, 0, 0);
        do_load(30, 20, 10, 29, 2, 2024); score();

        // Year wrap at 2^YEAR_W-1
        expect_out("yr_wrap_load", 59, 59, 23, 31, 12, 4095, 0, 0, 0, 0);
        do_load(59, 59, 23, 31, 12, 4095); score();
        start = 1;
        cyc();
        start = 0;
        repeat (CLK_DIV - 1) cyc();
        expect_out("yr_wrap_tick", 0, 0, 0, 1, 1, 0, 1, 1, 0, 0);
        cyc(); score();

        // Alarm by ticking into 07:30:00, then by loading it directly
        alarm_en = 1; alarm_hour = 8'd7; alarm_minute = 8'd30;
        expect_out("al_load", 59, 29, 7, 15, 6, 2024, 1, 0, 0, 0);
        do_load(59, 29, 7, 15, 6, 2024); score();
        repeat (CLK_DIV - 1) cyc();
        expect_out("al_tick", 0, 30, 7, 15, 6, 2024, 1, 1, 1, 0);
        cyc(); score();
        expect_out("al_once", 0, 30, 7, 15, 6, 2024, 1, 0, 0, 0);
        cyc(); score();
        expect_out("al_direct_load", 0, 30, 7, 15, 6, 2024, 1, 0, 0, 0);
        do_load(0, 30, 7, 15, 6, 2024); score();
        repeat (CLK_DIV - 1) cyc();
        expect_out("al_next_sec", 1, 30, 7, 15, 6, 2024, 1, 1, 0, 0);
        cyc(); score();

        // Load coincident with a tick that would have raised the alarm
        expect_out("co_prep", 59, 29, 7, 15, 6, 2024, 1, 0, 0, 0);
        do_load(59, 29, 7, 15, 6, 2024); score();
        repeat (CLK_DIV - 1) cyc();
        expect_out("co_load", 5, 6, 7, 8, 9, 2030, 1, 0, 0, 0);
        do_load(5, 6, 7, 8, 9, 2030); score();
        repeat (CLK_DIV - 1) cyc();
        expect_out("co_next_tick", 6, 6, 7, 8, 9, 2030, 1, 1, 0, 0);
        cyc(); score();

        // Alarm disabled: matching time produces no pulse
        alarm_en = 0;
        expect_out("aloff_load", 59, 29, 7, 15, 6, 2024, 1, 0, 0, 0);
        do_load(59, 29, 7, 15, 6, 2024); score();
        repeat (CLK_DIV - 1) cyc();
        expect_out("aloff_tick", 0, 30, 7, 15, 6, 2024, 1, 1, 0, 0);
        cyc(); score();

        // Asynchronous reset between clock edges
        repeat (2) cyc();
        #2;
        rst_n = 0;
        #1;
        expect_out("async_reset", 0, 0, 0, 1, 1, 2000, 0, 0, 0, 0);
        score();
        check("div1.async_reset_run", 32'(running1), 32'd0);
        check("div1.async_reset_sec", 32'(second1), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
